nios_fprint_scratchpad_dp: RTL

Parametrised dual-port processor scratchpad for the fingerprinting cores. It replaces the fixed 4096x32 single-port on-chip RAM. Two independent Avalon-MM slaves (s1 for the CPU data master, s2 for the fingerprint/DMA side) share one true-dual-port byte-enabled RAM. The block adds configurable read latency, same-address collision arbitration, and a hardware clear engine that zeroes the whole array after reset or on request.

---
 rtl/nios_fprint_scratchpad_pkg.sv | 22 ++
 rtl/nios_fprint_tdp_ram.sv | 48 ++++
 rtl/nios_fprint_scratchpad_dp.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/nios_fprint_scratchpad_pkg.sv
// Shared types and helpers for the dual-port fingerprint scratchpad.
package nios_fprint_scratchpad_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 12;
  localparam int BE_W           = DATA_W_DEFAULT / 8;
  localparam int DEPTH          = 2 ** ADDR_W_DEFAULT;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Same word on both ports is only a hazard when at least one side writes.
  function automatic logic is_collision(input logic [31:0] addr1,
                                        input logic [31:0] addr2,
                                        input logic        wr1,
                                        input logic        wr2);
    return (addr1 == addr2) && (wr1 || wr2);
  endfunction

endpackage

// File: rtl/nios_fprint_tdp_ram.sv
// Inferred true-dual-port byte-enabled RAM, one-cycle registered read on each port.
module nios_fprint_tdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_W-1:0]     a_addr_i,
  input  logic [DATA_W/8-1:0]   a_we_i,
  input  logic [DATA_W-1:0]     a_wdata_i,
  input  logic                  a_re_i,
  output logic [DATA_W-1:0]     a_rdata_o,
  input  logic [ADDR_W-1:0]     b_addr_i,
  input  logic [DATA_W/8-1:0]   b_we_i,
  input  logic [DATA_W-1:0]     b_wdata_i,
  input  logic                  b_re_i,
  output logic [DATA_W-1:0]     b_rdata_o
);

  localparam int NBYTES = DATA_W / 8;
  localparam int WORDS  = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  // The top never lets both ports write the same word in one cycle.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (a_we_i[i]) mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
      if (b_we_i[i]) mem_q[b_addr_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
    end
  end

  // Output registers only load on an accepted read so readdata holds between reads.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re_i) a_rdata_q <= mem_q[a_addr_i];
      if (b_re_i) b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/nios_fprint_scratchpad_dp.sv
// Dual-port Avalon-MM scratchpad with collision arbitration, freeze and a clear engine.
module nios_fprint_scratchpad_dp
  import nios_fprint_scratchpad_pkg::*;
#(
  parameter int DATA_W         = 8 * BE_W,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                clear_req,
  output logic                clear_busy,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic                s2_waitrequest,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid
);

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                freeze, clearing;
  logic                s1_cmd, s2_cmd, s2_coll, s1_stall, s2_stall;
  logic                s1_acc, s2_acc, s1_rd_acc, s2_rd_acc;
  logic [ADDR_W-1:0]   a_addr;
  logic [DATA_W/8-1:0] a_we, b_we;
  logic [DATA_W-1:0]   a_wdata, s1_rdata_p1, s2_rdata_p1;
  logic                s1_vld_p1_q, s2_vld_p1_q;

  assign freeze   = ~clken | reset_req;
  assign clearing = (state_q == CLEAR);

  assign s1_cmd   = s1_chipselect & (s1_read | s1_write);
  assign s2_cmd   = s2_chipselect & (s2_read | s2_write);
  assign s2_coll  = s1_cmd & s2_cmd &
                    is_collision(32'(s1_address), 32'(s2_address), s1_write, s2_write);
  assign s1_stall = freeze | clearing;
  assign s2_stall = s1_stall | s2_coll;

  // Outputs read 0 while reset is held, even though the FSM may already sit in CLEAR.
  assign s1_waitrequest = s1_stall & ~reset;
  assign s2_waitrequest = s2_stall & ~reset;
  assign clear_busy     = clearing & ~reset;

  assign s1_acc    = s1_cmd & ~s1_stall & ~reset;
  assign s2_acc    = s2_cmd & ~s2_stall & ~reset;
  assign s1_rd_acc = s1_acc & ~s1_write;
  assign s2_rd_acc = s2_acc & ~s2_write;

  // Port A belongs to the clear engine for the whole CLEAR sweep.
  assign a_addr  = clearing ? clr_cnt_q : s1_address;
  assign a_wdata = clearing ? '0 : s1_writedata;

  always_comb begin
    a_we = '0;
    if (clearing && !freeze && !reset) a_we = '1;
    else if (s1_acc && s1_write)       a_we = s1_byteenable;
  end

  always_comb begin
    b_we = '0;
    if (s2_acc && s2_write) b_we = s2_byteenable;
  end

  nios_fprint_tdp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i    (clk),
    .reset_i  (reset),
    .a_addr_i (a_addr),
    .a_we_i   (a_we),
    .a_wdata_i(a_wdata),
    .a_re_i   (s1_rd_acc),
    .a_rdata_o(s1_rdata_p1),
    .b_addr_i (s2_address),
    .b_we_i   (b_we),
    .b_wdata_i(s2_writedata),
    .b_re_i   (s2_rd_acc),
    .b_rdata_o(s2_rdata_p1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt_q <= '0;
    end else if (!freeze) begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
          end
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (&clr_cnt_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---- stage p1: RAM output register, valid tracks accepted reads ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_p1_q <= 1'b0;
      s2_vld_p1_q <= 1'b0;
    end else if (!freeze) begin
      s1_vld_p1_q <= s1_rd_acc;
      s2_vld_p1_q <= s2_rd_acc;
    end
  end

  // ---- stage p2: optional extra output register ----
  if (READ_LATENCY >= 2) begin : g_lat2
    logic              s1_vld_p2_q, s2_vld_p2_q;
    logic [DATA_W-1:0] s1_rdata_p2_q, s2_rdata_p2_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_vld_p2_q   <= 1'b0;
        s2_vld_p2_q   <= 1'b0;
        s1_rdata_p2_q <= '0;
        s2_rdata_p2_q <= '0;
      end else if (!freeze) begin
        s1_vld_p2_q <= s1_vld_p1_q;
        s2_vld_p2_q <= s2_vld_p1_q;
        if (s1_vld_p1_q) s1_rdata_p2_q <= s1_rdata_p1;
        if (s2_vld_p1_q) s2_rdata_p2_q <= s2_rdata_p1;
      end
    end

    assign s1_readdatavalid = s1_vld_p2_q & ~freeze;
    assign s2_readdatavalid = s2_vld_p2_q & ~freeze;
    assign s1_readdata      = s1_rdata_p2_q;
    assign s2_readdata      = s2_rdata_p2_q;
  end else begin : g_lat1
    assign s1_readdatavalid = s1_vld_p1_q & ~freeze;
    assign s2_readdatavalid = s2_vld_p1_q & ~freeze;
    assign s1_readdata      = s1_rdata_p1;
    assign s2_readdata      = s2_rdata_p1;
  end

endmodule
